// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of one SDRAM controller slave, one transaction in flight.
// Define SDRAM_ARB_LOCK_EN to add a_lock/b_lock grant locking with a 16-grant cap.
module sdram_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  input  logic [DATA_W/8-1:0] a_byteenable,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
`ifdef SDRAM_ARB_LOCK_EN
  input  logic                a_lock,
  input  logic                b_lock,
`endif
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  input  logic [DATA_W/8-1:0] b_byteenable,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  is_write_q, is_write_d;
  logic                  abandon_q, abandon_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   be_q, be_d;

  logic req_a, req_b, granted_req, winner;
  logic issue, rdwait;

  assign req_a       = a_read | a_write;
  assign req_b       = b_read | b_write;
  assign granted_req = (last_grant_q == GNT_B) ? req_b : req_a;

`ifdef SDRAM_ARB_LOCK_EN
  logic       lock_keep_q, lock_keep_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       granted_lock, keep_grant;

  assign granted_lock = (last_grant_q == GNT_B) ? b_lock : a_lock;
  // lock_cnt_q saturates at 15 on the 16th consecutive grant, which releases the lock
  assign keep_grant   = lock_keep_q && granted_req && (lock_cnt_q != 4'hF);
`endif

  always_comb begin : arbitrate
    if (req_a && req_b) begin
      winner = ~last_grant_q;
    end else begin
      winner = req_b;
    end
`ifdef SDRAM_ARB_LOCK_EN
    if (keep_grant) begin
      winner = last_grant_q;
    end
`endif
  end

  always_comb begin : next_state
    state_d      = state_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    abandon_d    = abandon_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
`ifdef SDRAM_ARB_LOCK_EN
    lock_keep_d  = lock_keep_q;
    lock_cnt_d   = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d      = ISSUE;
          last_grant_d = winner;
          is_write_d   = winner ? b_write : a_write;
          addr_d       = winner ? b_address : a_address;
          wdata_d      = winner ? b_writedata : a_writedata;
          be_d         = winner ? b_byteenable : a_byteenable;
          abandon_d    = 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
          if (winner != last_grant_q) begin
            lock_cnt_d = 4'd0;
          end else if (lock_cnt_q != 4'hF) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
          end
`endif
        end
      end
      ISSUE: begin
        // a requester dropping its strobe early still gets its command completed
        if (!granted_req) begin
          abandon_d = 1'b1;
        end
        if (!m_waitrequest) begin
          state_d = is_write_q ? IDLE : RDWAIT;
`ifdef SDRAM_ARB_LOCK_EN
          if (is_write_q) begin
            lock_keep_d = granted_lock;
          end
`endif
        end
      end
      RDWAIT: begin
        if (m_readdatavalid) begin
          state_d = IDLE;
`ifdef SDRAM_ARB_LOCK_EN
          lock_keep_d = granted_lock;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_B;
      is_write_q   <= 1'b0;
      abandon_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
`ifdef SDRAM_ARB_LOCK_EN
      lock_keep_q  <= 1'b0;
      lock_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      abandon_q    <= abandon_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
`ifdef SDRAM_ARB_LOCK_EN
      lock_keep_q  <= lock_keep_d;
      lock_cnt_q   <= lock_cnt_d;
`endif
    end
  end

  // Outputs are qualified by reset_n so they read idle during reset from the first cycle.
  always_comb begin : outputs
    issue           = reset_n && (state_q == ISSUE);
    rdwait          = reset_n && (state_q == RDWAIT);
    m_read          = issue && !is_write_q;
    m_write         = issue && is_write_q;
    m_address       = issue ? addr_q : '0;
    m_writedata     = issue ? wdata_q : '0;
    m_byteenable    = issue ? be_q : '0;
    a_waitrequest   = (issue && (last_grant_q == GNT_A)) ? m_waitrequest : 1'b1;
    b_waitrequest   = (issue && (last_grant_q == GNT_B)) ? m_waitrequest : 1'b1;
    a_readdata      = m_readdata;
    b_readdata      = m_readdata;
    a_readdatavalid = rdwait && !abandon_q && (last_grant_q == GNT_A) && m_readdatavalid;
    b_readdatavalid = rdwait && !abandon_q && (last_grant_q == GNT_B) && m_readdatavalid;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: scripted vector table, corner sequences, and a randomized
// two-requester / one-slave run checked against a requester-level memory and fairness model.
module tb_sdram_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic [ADDR_W-1:0] a_address, b_address, m_address;
  logic a_read, a_write, b_read, b_write, m_read, m_write;
  logic [DATA_W-1:0] a_writedata, b_writedata, m_writedata;
  logic [1:0] a_byteenable, b_byteenable, m_byteenable;
  logic a_waitrequest, b_waitrequest, m_waitrequest;
  logic [DATA_W-1:0] a_readdata, b_readdata, m_readdata;
  logic a_readdatavalid, b_readdatavalid, m_readdatavalid;
`ifdef SDRAM_ARB_LOCK_EN
  logic a_lock, b_lock;
  int   a_run;
  logic b_seen;
`endif

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_byteenable(a_byteenable), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
`ifdef SDRAM_ARB_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_byteenable(b_byteenable), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ar, aw, br, bw, mw, mrdv, input logic [15:0] mrd);
    reset_n = rst; a_read = ar; a_write = aw; b_read = br; b_write = bw;
    m_waitrequest = mw; m_readdatavalid = mrdv; m_readdata = mrd;
  endtask

  // One cycle: drive just after the rising edge, then let outputs settle before sampling.
  task automatic step_in(input logic rst, ar, aw, br, bw, mw, mrdv, input logic [15:0] mrd);
    @(posedge clk);
    #1;
    drive(rst, ar, aw, br, bw, mw, mrdv, mrd);
    #2;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    merge = o;
    if (be[0]) merge[7:0] = n[7:0];
    if (be[1]) merge[15:8] = n[15:8];
  endfunction

  // in = {rst_n, a_read, a_write, b_read, b_write, m_waitrequest, m_readdatavalid}
  // ctl = {m_read, m_write, a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid}
  typedef struct {
    logic [6:0]  in;
    logic [15:0] mrd;
    logic [5:0]  ctl;
    logic [24:0] addr;
    logic [15:0] data;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [6:0] in, input logic [15:0] mrd, input logic [5:0] ctl,
                              input logic [24:0] addr, input logic [15:0] data);
    vec_t v;
    v.in = in; v.mrd = mrd; v.ctl = ctl; v.addr = addr; v.data = data;
    return v;
  endfunction

  typedef struct {
    logic        rd, wr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
  } cmd_t;
  cmd_t        cmd[2];
  logic        busy[2];
  int          pend_since[2];
  logic [15:0] ref_mem[16];
  logic [15:0] slv_mem[16];
  logic        rd_pending, beat, gen, drained, macc, unfair;
  int          rd_cnt, exp_rd_port, last_p, last_c, p;
  logic [15:0] rd_data, exp_rd_val;
  logic [1:0]  exp_v;
  int          order[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_address = 25'h10; b_address = 25'h20;
    a_writedata = 16'h1234; b_writedata = 16'h5678;
    a_byteenable = 2'b11; b_byteenable = 2'b11;
`ifdef SDRAM_ARB_LOCK_EN
    a_lock = 1'b0; b_lock = 1'b0;
`endif
    drive(1'b0, 0, 0, 0, 0, 0, 0, 16'h0);

    // Reset, single write, tied reads, spurious valid, stalled write.
    tbl.push_back(mk(7'b0_01_10_0_1, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b0_01_10_0_1, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_01_00_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_01_00_0_0, 16'h0,    6'b01_01_00, 25'h10, 16'h1234));
    tbl.push_back(mk(7'b1_00_00_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b0_00_00_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_10_10_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_10_10_0_0, 16'h0,    6'b10_01_00, 25'h10, 16'h0));
    tbl.push_back(mk(7'b1_00_10_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_00_10_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_00_10_0_1, 16'hBEEF, 6'b00_11_10, 25'h0,  16'hBEEF));
    tbl.push_back(mk(7'b1_00_10_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_00_10_0_0, 16'h0,    6'b10_10_00, 25'h20, 16'h0));
    tbl.push_back(mk(7'b1_00_00_0_1, 16'h0BAD, 6'b00_11_01, 25'h0,  16'h0BAD));
    tbl.push_back(mk(7'b1_00_00_0_1, 16'hDEAD, 6'b00_11_00, 25'h0,  16'h0));
    tbl.push_back(mk(7'b1_01_00_1_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(7'b1_01_00_1_0, 16'h0,  6'b01_11_00, 25'h10, 16'h1234));
    tbl.push_back(mk(7'b1_01_00_0_0, 16'h0,    6'b01_01_00, 25'h10, 16'h1234));
    tbl.push_back(mk(7'b1_00_00_0_0, 16'h0,    6'b00_11_00, 25'h0,  16'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      step_in(tbl[i].in[6], tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2],
              tbl[i].in[1], tbl[i].in[0], tbl[i].mrd);
      chk($sformatf("vec%0d_ctl", i),
          {m_read, m_write, a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid}, tbl[i].ctl);
      chk($sformatf("vec%0d_addr", i), m_address, tbl[i].addr);
      if (tbl[i].ctl[4] || !tbl[i].in[6])
        chk($sformatf("vec%0d_wdata", i), {m_writedata, m_byteenable},
            {tbl[i].data, tbl[i].in[6] ? 2'b11 : 2'b00});
      if (tbl[i].ctl[1]) chk($sformatf("vec%0d_ardata", i), a_readdata, tbl[i].data);
      if (tbl[i].ctl[0]) chk($sformatf("vec%0d_brdata", i), b_readdata, tbl[i].data);
    end

    // Both ports write continuously: grants alternate starting with A.
    step_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    for (int c = 0; c < 80 && order.size() < 8; c++) begin
      step_in(1, 0, 1, 0, 1, 0, 0, 16'h0);
      if (!a_waitrequest) order.push_back(0);
      if (!b_waitrequest) order.push_back(1);
    end
    chk("rr_count", order.size(), 8);
    for (int i = 0; i < order.size(); i++) chk($sformatf("rr_grant%0d", i), order[i], i % 2);

    // Requester drops its read before acceptance: command completes, data discarded.
    step_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    step_in(1, 1, 0, 0, 0, 1, 0, 16'h0);
    step_in(1, 1, 0, 0, 0, 1, 0, 16'h0);
    chk("abn_issue", {m_read, a_waitrequest}, 2'b11);
    step_in(1, 0, 0, 0, 0, 1, 0, 16'h0);
    chk("abn_hold", {m_read, m_address}, {1'b1, 25'h10});
    step_in(1, 0, 0, 0, 0, 0, 0, 16'h0);
    chk("abn_accept", m_read, 1);
    step_in(1, 0, 0, 0, 0, 0, 1, 16'h7777);
    chk("abn_discard", {a_readdatavalid, b_readdatavalid}, 2'b00);

    // Reset during RDWAIT, then a late valid beat.
    step_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    step_in(1, 1, 0, 0, 0, 0, 0, 16'h0);
    step_in(1, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("rst_rd_issue", {m_read, a_waitrequest}, 2'b10);
    step_in(1, 0, 0, 0, 0, 0, 0, 16'h0);
    step_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    chk("rst_rd_inreset", {m_read, a_readdatavalid, a_waitrequest}, 3'b001);
    step_in(1, 0, 0, 1, 0, 0, 1, 16'hCAFE);
    chk("rst_rd_late", {a_readdatavalid, b_readdatavalid, m_read}, 3'b000);
    step_in(1, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("rst_rd_idle", {m_read, m_address, b_waitrequest}, {1'b1, 25'h20, 1'b0});

    // Randomized traffic against requester-level memory and fairness model.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'hA000 + 16'(i);
      slv_mem[i] = 16'hA000 + 16'(i);
    end
    busy[0] = 0; busy[1] = 0; pend_since[0] = 0; pend_since[1] = 0;
    rd_pending = 0; rd_cnt = 0; rd_data = 0; exp_rd_port = 0; exp_rd_val = 0;
    last_p = -1; last_c = 0; drained = 0;
    step_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    for (int c = 0; c < 6000; c++) begin
      gen = (c < 4000);
      if (!gen && !busy[0] && !busy[1] && !rd_pending) begin
        drained = 1;
        break;
      end
      @(posedge clk);
      #1;
      for (int q = 0; q < 2; q++) begin
        if (gen && !busy[q] && $urandom_range(0, 2) == 0) begin
          int kind;
          kind = $urandom_range(0, 3);
          cmd[q].rd   = (kind != 2);
          cmd[q].wr   = (kind >= 2);
          cmd[q].addr = 4'($urandom_range(0, 15));
          cmd[q].data = 16'($urandom);
          cmd[q].be   = 2'($urandom_range(0, 3));
          busy[q] = 1;
          pend_since[q] = c;
        end
      end
      reset_n = 1;
      a_read = busy[0] && cmd[0].rd; a_write = busy[0] && cmd[0].wr;
      a_address = {21'b0, cmd[0].addr}; a_writedata = cmd[0].data; a_byteenable = cmd[0].be;
      b_read = busy[1] && cmd[1].rd; b_write = busy[1] && cmd[1].wr;
      b_address = {21'b0, cmd[1].addr}; b_writedata = cmd[1].data; b_byteenable = cmd[1].be;
      m_waitrequest = ($urandom_range(0, 2) == 0);
      beat = rd_pending && (rd_cnt == 0);
      if (rd_pending && rd_cnt != 0) rd_cnt--;
      if (beat) begin
        m_readdatavalid = 1; m_readdata = rd_data; rd_pending = 0;
      end else begin
        m_readdatavalid = !rd_pending && ($urandom_range(0, 4) == 0);
        m_readdata = 16'($urandom);
      end
      #2;
      macc = (m_read || m_write) && !m_waitrequest;
      chk("handshake", {~a_waitrequest | ~b_waitrequest, ~a_waitrequest & ~b_waitrequest}, {macc, 1'b0});
      if (macc && (!a_waitrequest || !b_waitrequest)) begin
        p = !a_waitrequest ? 0 : 1;
        chk("req_live", busy[p], 1);
        chk("cmd_fields",
            {m_read, m_write, m_address, cmd[p].wr ? {m_writedata, m_byteenable} : 18'b0},
            {~cmd[p].wr, cmd[p].wr, 21'b0, cmd[p].addr, cmd[p].wr ? {cmd[p].data, cmd[p].be} : 18'b0});
        unfair = (last_p == p) && busy[1-p] && (pend_since[1-p] <= last_c);
        chk("fairness", unfair, 0);
        if (m_write)
          slv_mem[m_address[3:0]] = merge(slv_mem[m_address[3:0]], m_writedata, m_byteenable);
        if (m_read) begin
          rd_data = slv_mem[m_address[3:0]];
          rd_pending = 1;
          rd_cnt = $urandom_range(0, 3);
        end
        if (cmd[p].wr) begin
          ref_mem[cmd[p].addr] = merge(ref_mem[cmd[p].addr], cmd[p].data, cmd[p].be);
        end else begin
          exp_rd_port = p;
          exp_rd_val = ref_mem[cmd[p].addr];
        end
        busy[p] = 0; last_p = p; last_c = c;
      end
      exp_v = beat ? ((exp_rd_port == 0) ? 2'b10 : 2'b01) : 2'b00;
      chk("rdvalid", {a_readdatavalid, b_readdatavalid}, exp_v);
      if (beat) chk("rddata", (exp_rd_port == 0) ? a_readdata : b_readdata, exp_rd_val);
    end
    chk("drain", drained, 1);

`ifdef SDRAM_ARB_LOCK_EN
    // A locked and requesting against B: 16 A grants, then B.
    step_in(0, 0, 0, 0, 0, 0, 0, 16'h0);
    a_lock = 1; a_run = 0; b_seen = 0;
    for (int c = 0; c < 200 && !b_seen; c++) begin
      step_in(1, 0, 1, 0, 1, 0, 0, 16'h0);
      if (!b_waitrequest) b_seen = 1;
      else if (!a_waitrequest) a_run++;
    end
    chk("lock_b_granted", b_seen, 1);
    chk("lock_a_run", a_run, 16);
    a_lock = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
